// File: rtl/mctl_pkg.sv
// Shared constants and helpers for the motor control/timing block.
// Contents: register bit positions, the watchdog clear code and the
// hardware-configuration word builder used for the hwconfig readback.
package mctl_pkg;

   localparam int CTRL_EN_BIT    = 5;
   localparam int CFG_INVPWM_BIT = 6;
   localparam int CFG_INVPH_BIT  = 7;

   localparam logic [7:0] WDOG_CLEAR_CODE = 8'h80;

   // Layout: {1'b0, channel count[2:0], 2'b00, divisor-select width[1:0]}
   function automatic logic [7:0] mctl_hwconfig(input logic [2:0] nch, input logic [1:0] divw);
      return {1'b0, nch, 2'b00, divw};
   endfunction

endpackage

// File: rtl/mctl_cediv.sv
// Clock-enable divider: free-running counter advancing on cein; ceout
// fires on cein when the low 'sel' counter bits are all ones, giving a
// divide by 2^sel. sel = 0 passes cein straight through. A select change
// takes effect at once without resetting the counter.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   cein        input enable
//   sel         divide select (log2 of ratio)
//   ceout       divided enable, held low during reset
module mctl_cediv #(
   parameter int DIVW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cein,
   input  logic [DIVW-1:0] sel,
   output logic            ceout
);

   localparam int CW = (1 << DIVW) - 1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    cnt <= '0;
      else if (cein) cnt <= cnt + 1'b1;
   end

   assign mask  = ~({CW{1'b1}} << sel);
   // rst_n gating keeps the pass-through path quiet while in reset.
   assign ceout = rst_n & cein & ((cnt & mask) == mask);

endmodule

// File: rtl/motor_ctrl_gen.sv
// Control/timing block for an N-channel brushed-DC motor controller.
// Holds per-channel config registers, the control register and the
// watchdog; generates PWM-count and filter clock enables.
// Optional feature macro: MCTL_LEDALIVE_EN adds the ledalive heartbeat
// output (10-bit counter on the slow watchdog tick, MSB drives the LED).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cfgld/ctrlld/wdogdivld/wrtdata  host load strobes and write data
//   tst                             fast watchdog tick select
//   wdogdis                         async watchdog disable (synchronised)
//   wdreset                         watchdog kick
//   pwmcntce, filterce              per-channel clock enables
//   invertpwm, invphase, run        per-channel control bits
//   motorena, wdtrip                global enable, watchdog trip flag
//   controlrdata, cfgrdata, wdogdivrdata, hwconfig   readbacks
//   ledalive                        heartbeat (MCTL_LEDALIVE_EN only)
module motor_ctrl_gen
   import mctl_pkg::*;
#(
   parameter int NCH     = 3,
   parameter int DIVW    = 2,
   parameter int BASEDIV = 5,
   parameter int WDSLOW  = 9,
   parameter int WDW     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NCH-1:0]     cfgld,
   input  logic               ctrlld,
   input  logic               wdogdivld,
   input  logic [7:0]         wrtdata,
   input  logic               tst,
   input  logic               wdogdis,
   input  logic               wdreset,
   output logic [NCH-1:0]     pwmcntce,
   output logic [NCH-1:0]     filterce,
   output logic [NCH-1:0]     invertpwm,
   output logic [NCH-1:0]     invphase,
   output logic [NCH-1:0]     run,
   output logic               motorena,
   output logic               wdtrip,
   output logic [7:0]         controlrdata,
   output logic [8*NCH-1:0]   cfgrdata,
   output logic [WDW-1:0]     wdogdivrdata,
   output logic [7:0]         hwconfig
`ifdef MCTL_LEDALIVE_EN
   ,
   output logic               ledalive
`endif
);

   localparam logic [7:0] CFG_MASK = 8'hC0 | 8'((1 << (2*DIVW)) - 1);
   localparam logic [4:0] RUN_MASK = 5'((1 << NCH) - 1);

   logic [BASEDIV-1:0]    pre_cnt;
   logic                  base_ce;
   logic                  fast_ph;
   logic                  fast_ce;
   logic [WDSLOW-1:0]     slow_cnt;
   logic                  slow_ce;
   logic                  wd_ce;
   logic                  dis_meta;
   logic                  dis_sync;
   logic [NCH-1:0][7:0]   cfg_q;
   logic [4:0]            run_q;
   logic                  en_q;
   logic [WDW-1:0]        wdogdiv_q;
   logic [WDW-1:0]        wd_cnt;
   logic                  counting;
   logic                  trip_cond;
   logic                  trip_clr;

   // Prescaler chain: base tick, every 2nd base tick, every 2^WDSLOW fast tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt  <= '0;
         base_ce  <= 1'b0;
         fast_ph  <= 1'b0;
         slow_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
         base_ce <= &pre_cnt;
         if (base_ce) fast_ph  <= ~fast_ph;
         if (fast_ce) slow_cnt <= slow_cnt + 1'b1;
      end
   end

   assign fast_ce = base_ce & fast_ph;
   assign slow_ce = fast_ce & (&slow_cnt);
   assign wd_ce   = tst ? fast_ce : slow_ce;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dis_meta <= 1'b0;
         dis_sync <= 1'b0;
      end else begin
         dis_meta <= wdogdis;
         dis_sync <= dis_meta;
      end
   end

   // Config and divisor registers are locked while the motors are enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q     <= '0;
         wdogdiv_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (cfgld[i] && !motorena) cfg_q[i] <= wrtdata & CFG_MASK;
         end
         if (wdogdivld && !motorena) wdogdiv_q <= wrtdata[WDW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= '0;
         en_q  <= 1'b0;
      end else if (ctrlld) begin
         run_q <= wrtdata[4:0] & RUN_MASK;
         en_q  <= wrtdata[CTRL_EN_BIT];
      end
   end

   assign counting  = motorena & ~wdreset & ~dis_sync;
   assign trip_cond = wd_ce & counting & (wd_cnt == wdogdiv_q);
   assign trip_clr  = ctrlld & (wrtdata == WDOG_CLEAR_CODE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
         wdtrip <= 1'b0;
      end else begin
         if (!counting)  wd_cnt <= '0;
         else if (wd_ce) wd_cnt <= wd_cnt + 1'b1;
         // A host clear outranks a simultaneous trip.
         if (trip_clr)       wdtrip <= 1'b0;
         else if (trip_cond) wdtrip <= 1'b1;
      end
   end

   assign motorena = en_q & ~wdtrip;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      mctl_cediv #(.DIVW(DIVW)) u_pwm_div (
         .clk   (clk),
         .rst_n (rst_n),
         .cein  (1'b1),
         .sel   (cfg_q[i][DIVW-1:0]),
         .ceout (pwmcntce[i])
      );
      mctl_cediv #(.DIVW(DIVW)) u_flt_div (
         .clk   (clk),
         .rst_n (rst_n),
         .cein  (base_ce),
         .sel   (cfg_q[i][2*DIVW-1:DIVW]),
         .ceout (filterce[i])
      );
      assign invertpwm[i] = cfg_q[i][CFG_INVPWM_BIT];
      assign invphase[i]  = cfg_q[i][CFG_INVPH_BIT];
   end

   assign run          = run_q[NCH-1:0];
   assign cfgrdata     = cfg_q;
   assign wdogdivrdata = wdogdiv_q;
   assign controlrdata = {wdtrip, dis_sync, en_q, run_q};
   assign hwconfig     = mctl_hwconfig(3'(NCH), 2'(DIVW));

`ifdef MCTL_LEDALIVE_EN
   logic [9:0] led_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       led_cnt <= '0;
      else if (slow_ce) led_cnt <= led_cnt + 1'b1;
   end

   assign ledalive = led_cnt[9];
`endif

endmodule
